// File: rtl/alu_cmd_frontend.sv
// alu_cmd_frontend: turns 3-byte command frames (header A<op>, operand A,
// operand B) from a UART receiver into ALU operand/opcode registers, waits a
// fixed ALU latency, then returns the 8-bit result through a valid/ready
// transmit port. Malformed or unexpected bytes bump a saturating error count.
//
// Build option: define ALU_CMD_TIMEOUT_EN to enable an inter-byte gap timeout
// while a frame is partially received (GET_A/GET_B). Without it the frame
// waits indefinitely and TIMEOUT_CYCLES has no hardware effect.
//
// Note: reset_n is an active-high synchronous reset despite its name.
module alu_cmd_frontend #(
    parameter int ALU_LAT        = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_result,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    // Elaboration-time guard against out-of-range configuration.
    if (ALU_LAT < 1 || ALU_LAT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("alu_cmd_frontend: ALU_LAT must be 1..15 and TIMEOUT_CYCLES 1..65535");
    end

    // Counter value seen on the edge that should capture alu_result.
    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    wire w_srst = reset_n;

    state_t     r_state, w_state_next;
    logic [3:0] r_opcode, w_opcode_next;
    logic [3:0] r_a, w_a_next;
    logic [3:0] r_alu_op, w_alu_op_next;
    logic [3:0] r_alu_a, w_alu_a_next;
    logic [3:0] r_alu_b, w_alu_b_next;
    logic [7:0] r_tx_data, w_tx_data_next;
    logic       r_tx_valid, w_tx_valid_next;
    logic [7:0] r_err_count, w_err_count_next;
    logic [3:0] r_lat_cnt, w_lat_cnt_next;
    logic       w_err;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_gap_cnt, w_gap_cnt_next;
`endif

    // Next-state, datapath and error-source decode.
    always_comb begin
        w_state_next     = r_state;
        w_opcode_next    = r_opcode;
        w_a_next         = r_a;
        w_alu_op_next    = r_alu_op;
        w_alu_a_next     = r_alu_a;
        w_alu_b_next     = r_alu_b;
        w_tx_data_next   = r_tx_data;
        w_tx_valid_next  = r_tx_valid;
        w_lat_cnt_next   = r_lat_cnt;
        w_err            = 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
        w_gap_cnt_next   = r_gap_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data[7:4] == 4'hA) begin
                        w_opcode_next = rx_data[3:0];
                        w_state_next  = S_GET_A;
`ifdef ALU_CMD_TIMEOUT_EN
                        w_gap_cnt_next = '0;
`endif
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_GET_A, S_GET_B: begin
                if (rx_valid) begin
                    if (r_state == S_GET_A) begin
                        w_a_next     = rx_data[3:0];
                        w_state_next = S_GET_B;
                    end else begin
                        // All three ALU inputs change together on this edge.
                        w_alu_op_next  = r_opcode;
                        w_alu_a_next   = r_a;
                        w_alu_b_next   = rx_data[3:0];
                        w_lat_cnt_next = '0;
                        w_state_next   = S_WAIT;
                    end
`ifdef ALU_CMD_TIMEOUT_EN
                    w_gap_cnt_next = '0;
                end else if (r_gap_cnt == GAP_LAST) begin
                    // Abandon the partial frame; ALU outputs keep their values.
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 16'd1;
`endif
                end
            end
            S_WAIT: begin
                w_err = rx_valid;
                if (r_lat_cnt == LAT_LAST) begin
                    w_tx_data_next  = alu_result;
                    w_tx_valid_next = 1'b1;
                    w_state_next    = S_SEND;
                end else begin
                    w_lat_cnt_next = r_lat_cnt + 4'd1;
                end
            end
            S_SEND: begin
                w_err = rx_valid;
                if (tx_ready) begin
                    w_tx_valid_next = 1'b0;
                    w_alu_op_next   = 4'h0;
                    w_state_next    = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // One increment per cycle at most, saturating at 0xFF.
        w_err_count_next = (w_err && r_err_count != 8'hFF) ? r_err_count + 8'd1 : r_err_count;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (w_srst) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_a         <= '0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_err_count <= '0;
            r_lat_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_opcode    <= w_opcode_next;
            r_a         <= w_a_next;
            r_alu_op    <= w_alu_op_next;
            r_alu_a     <= w_alu_a_next;
            r_alu_b     <= w_alu_b_next;
            r_tx_data   <= w_tx_data_next;
            r_tx_valid  <= w_tx_valid_next;
            r_err_count <= w_err_count_next;
            r_lat_cnt   <= w_lat_cnt_next;
        end
    end

`ifdef ALU_CMD_TIMEOUT_EN
    // Inter-byte gap counter, only meaningful while a frame is half received.
    always_ff @(posedge clk) begin
        if (w_srst) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= w_gap_cnt_next;
        end
    end
`endif

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign err_count = r_err_count;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Directed testbench for alu_cmd_frontend with a 1-cycle registered ALU model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_cmd_frontend;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] alu_op, alu_a, alu_b;
    logic [7:0] alu_result = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    alu_cmd_frontend #(.ALU_LAT(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // ALU model: 1 add, 2 subtract, 4 or, 6 multiply, anything else 0.
    always @(posedge clk) begin
        case (alu_op)
            4'd1:    alu_result <= {4'h0, alu_a} + {4'h0, alu_b};
            4'd2:    alu_result <= {4'h0, alu_a} - {4'h0, alu_b};
            4'd4:    alu_result <= {4'h0, alu_a | alu_b};
            4'd6:    alu_result <= {4'h0, alu_a} * {4'h0, alu_b};
            default: alu_result <= 8'h00;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Full frame with tx_ready high; checks latency, hold and return to idle.
    task automatic run_frame(input logic [3:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic [7:0] exp);
        send_byte({4'hA, op});
        send_byte({4'h5, a});
        send_byte({4'hC, b});
        check("alu_op_after_b", {4'h0, alu_op}, {4'h0, op});
        check("alu_a_after_b", {4'h0, alu_a}, {4'h0, a});
        check("alu_b_after_b", {4'h0, alu_b}, {4'h0, b});
        check("busy_wait", {7'h0, busy}, 8'h01);
        @(negedge clk);
        check("tx_valid_early", {7'h0, tx_valid}, 8'h00);
        @(negedge clk);
        check("tx_valid_lat", {7'h0, tx_valid}, 8'h01);
        check("tx_data", tx_data, exp);
        check("alu_op_hold", {4'h0, alu_op}, {4'h0, op});
        @(negedge clk);
        check("tx_valid_clear", {7'h0, tx_valid}, 8'h00);
        check("busy_idle", {7'h0, busy}, 8'h00);
        check("alu_op_zero", {4'h0, alu_op}, 8'h00);
        check("alu_a_retain", {4'h0, alu_a}, {4'h0, a});
        $display("frame op=%0h a=%0h b=%0h result=%0h", op, a, b, tx_data);
    endtask

    initial begin
        logic [7:0] e0;
        vecs[0] = '{op: 4'd1, a: 4'h3, b: 4'h2, exp: 8'h05};
        vecs[1] = '{op: 4'd2, a: 4'h5, b: 4'h1, exp: 8'h04};
        vecs[2] = '{op: 4'd4, a: 4'hC, b: 4'h3, exp: 8'h0F};
        vecs[3] = '{op: 4'd6, a: 4'h7, b: 4'h7, exp: 8'h31};
        vecs[4] = '{op: 4'd1, a: 4'hF, b: 4'hF, exp: 8'h1E};
        vecs[5] = '{op: 4'd2, a: 4'h0, b: 4'h1, exp: 8'hFF};

        // Reset with a stray byte present: it must be ignored.
        @(negedge clk);
        reset_n  = 1'b1;
        rx_data  = 8'hA1;
        rx_valid = 1'b1;
        @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        check("rst_busy", {7'h0, busy}, 8'h00);
        check("rst_tx_valid", {7'h0, tx_valid}, 8'h00);
        check("rst_err", err_count, 8'h00);
        check("rst_alu_op", {4'h0, alu_op}, 8'h00);
        $display("reset done");

        // Table-driven frames, sent back to back.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Bad header: stays idle, one error.
        send_byte(8'h5F);
        check("badhdr_busy", {7'h0, busy}, 8'h00);
        check("badhdr_err", err_count, 8'h01);
        check("badhdr_txv", {7'h0, tx_valid}, 8'h00);
        $display("bad header 5f err=%0d", err_count);

        // Stalled transmitter: response held 10 cycles, extra byte dropped.
        tx_ready = 1'b0;
        send_byte(8'hA6);
        send_byte(8'h07);
        send_byte(8'h07);
        @(negedge clk);
        @(negedge clk);
        e0 = err_count;
        for (int i = 0; i < 10; i++) begin
            check("stall_txv", {7'h0, tx_valid}, 8'h01);
            check("stall_data", tx_data, 8'h31);
            rx_data  = 8'hA1;
            rx_valid = (i == 3);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("stall_err", err_count, 8'h02);
        tx_ready = 1'b1;
        @(negedge clk);
        check("stall_release_txv", {7'h0, tx_valid}, 8'h00);
        check("stall_release_busy", {7'h0, busy}, 8'h00);
        check("stall_err_delta", err_count - e0, 8'h01);
        $display("stalled frame a6 07 07 result=31 err=%0d", err_count);

        // 300 bad headers saturate the error count.
        rx_data  = 8'h5F;
        rx_valid = 1'b1;
        repeat (300) @(negedge clk);
        rx_valid = 1'b0;
        check("sat_err", err_count, 8'hFF);
        $display("300 bad headers err=%0h", err_count);

        // Reset in the middle of a frame.
        send_byte(8'hA1);
        send_byte(8'h03);
        reset_n  = 1'b1;
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        check("midrst_err", err_count, 8'h00);
        check("midrst_busy", {7'h0, busy}, 8'h00);
        check("midrst_alu_a", {4'h0, alu_a}, 8'h00);
        check("midrst_alu_b", {4'h0, alu_b}, 8'h00);
        check("midrst_txd", tx_data, 8'h00);
        @(negedge clk);
        check("midrst_no_resp", {7'h0, tx_valid}, 8'h00);
        $display("mid-frame reset done");
        run_frame(4'd4, 4'hC, 4'h3, 8'h0F);

`ifdef ALU_CMD_TIMEOUT_EN
        // Header then silence: back to idle after 8 cycles.
        send_byte(8'hA1);
        repeat (7) @(negedge clk);
        check("to_busy_before", {7'h0, busy}, 8'h01);
        @(negedge clk);
        check("to_busy_after", {7'h0, busy}, 8'h00);
        check("to_err", err_count, 8'h01);
        check("to_alu_a_kept", {4'h0, alu_a}, 8'h0C);
        $display("timeout err=%0d", err_count);
        run_frame(4'd2, 4'h5, 4'h1, 8'h04);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
